// File: rtl/generator_arbiter.sv
// generator_arbiter: round-robin sharing of one generator core among NUM_REQ requesters.
// Yields are buffered in a 2-entry FIFO and tagged with the owner's id; Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

module generator_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2,
   parameter int NUM_ARGS = 4,
   parameter int NUM_OUTS = 2,
   parameter int WIDTH    = 32
) (
   input  logic                             _clock,
   input  logic                             _reset_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*NUM_ARGS*WIDTH-1:0] req_args,
   output logic                             gen_start,
   output logic [NUM_ARGS*WIDTH-1:0]        gen_args,
   output logic                             gen_ready,
   input  logic                             gen_valid,
   input  logic [NUM_OUTS*WIDTH-1:0]        gen_out,
   input  logic                             gen_done,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [ID_WIDTH-1:0]              resp_id,
   output logic [NUM_OUTS*WIDTH-1:0]        resp_data,
   output logic                             resp_last
);

   localparam int ARG_W = NUM_ARGS * WIDTH;
   localparam int OUT_W = NUM_OUTS * WIDTH;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      LAST  = 3'd4
   } state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] grant_id;
   logic [ID_WIDTH-1:0] grant_idx;
   logic [ID_WIDTH-1:0] cand;
   logic                grant_hit;

   logic [OUT_W-1:0]    fifo_mem [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign push  = (state == RUN) && gen_valid && gen_ready;
   assign pop   = ((state == RUN) || (state == DRAIN)) && !empty && resp_ready;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
         if (!grant_hit && req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Gated by reset so no accept can be signalled while the block is held in reset.
   always_comb begin
      req_ready = '0;
      if (_reset_n && (state == IDLE) && grant_hit)
         req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      gen_start  = (state == START);
      gen_ready  = (state == RUN) && !full;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_id    = '0;
      resp_data  = '0;
      case (state)
         RUN, DRAIN: begin
            resp_valid = !empty;
            resp_id    = grant_id;
            resp_data  = empty ? '0 : fifo_mem[rd_ptr];
         end
         LAST: begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            resp_id    = grant_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         gen_args    <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= gen_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);

         case (state)
            IDLE: begin
               if (grant_hit) begin
                  gen_args <= req_args[int'(grant_idx)*ARG_W +: ARG_W];
                  grant_id <= grant_idx;
                  rr_ptr   <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + ID_WIDTH'(1);
                  state    <= START;
               end
            end
            // gen_done may be stale from the previous run here, so it is not looked at.
            START: state <= RUN;
            RUN: begin
               if (gen_done)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (empty)
                  state <= LAST;
            end
            LAST: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_generator_arbiter.sv
// Directed bench for generator_arbiter with a small behavioural generator model.
`timescale 1ns/1ps

module tb_generator_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int ID_WIDTH = 2;
   localparam int NUM_ARGS = 4;
   localparam int NUM_OUTS = 2;
   localparam int WIDTH    = 32;
   localparam int ARG_W    = NUM_ARGS * WIDTH;

   logic                              clk;
   logic                              rst_n;
   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ*NUM_ARGS*WIDTH-1:0] req_args;
   logic                              gen_start;
   logic [ARG_W-1:0]                  gen_args;
   logic                              gen_ready;
   logic                              gen_valid;
   logic [NUM_OUTS*WIDTH-1:0]         gen_out;
   logic                              gen_done;
   logic                              resp_valid;
   logic                              resp_ready;
   logic [ID_WIDTH-1:0]               resp_id;
   logic [NUM_OUTS*WIDTH-1:0]         resp_data;
   logic                              resp_last;

   generator_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .NUM_ARGS(NUM_ARGS),
      .NUM_OUTS(NUM_OUTS), .WIDTH(WIDTH)
   ) dut (
      ._clock(clk), ._reset_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_args(req_args),
      .gen_start(gen_start), .gen_args(gen_args), .gen_ready(gen_ready),
      .gen_valid(gen_valid), .gen_out(gen_out), .gen_done(gen_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_last(resp_last)
   );

   typedef struct {
      logic [1:0]  id;
      logic        last;
      logic [63:0] data;
      int          cyc;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   beat_t       beats[$];
   beat_t       mon_b;
   int          grants[$];
   int          grant_cyc[$];
   int          start_pulses = 0;
   bit          stale_seen = 0;
   bit          coincide_seen = 0;
   int          done_cyc = 0;
   int          fire_count = 0;
   logic [63:0] prog_q[$];
   int          prog_delay = 0;
   bit          prog_early = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Observe handshakes mid-cycle, away from the clock edge.
   initial forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
         mon_b.id = resp_id; mon_b.last = resp_last; mon_b.data = resp_data; mon_b.cyc = cyc;
         beats.push_back(mon_b);
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) begin grants.push_back(i); grant_cyc.push_back(cyc); end
      if (gen_start) begin
         start_pulses++;
         if (gen_done) stale_seen = 1;
      end
      if (gen_valid && gen_ready && gen_done) coincide_seen = 1;
   end

   // Generator model: yields prog_q in order, then raises a sticky done after prog_delay cycles.
   initial begin
      logic [63:0] gq[$];
      bit fire, started, run;
      int delay;
      gen_valid = 1'b0; gen_out = '0; gen_done = 1'b0; run = 0; delay = 0;
      forever begin
         @(negedge clk);
         fire = gen_valid && gen_ready;
         started = gen_start;
         @(posedge clk); #1;
         if (started) begin
            gq = prog_q; gen_done = 1'b0; delay = prog_delay; run = 1;
         end else if (fire && gq.size() > 0) begin
            void'(gq.pop_front());
            fire_count++;
         end
         if (run && (gq.size() == 0 || (prog_early && gq.size() == 1))) begin
            if (delay > 0) delay--;
            else begin gen_done = 1'b1; run = 0; done_cyc = cyc; end
         end
         gen_valid = (gq.size() > 0);
         gen_out   = gen_valid ? gq[0] : '0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic int count_lasts();
      int n = 0;
      foreach (beats[i]) if (beats[i].last) n++;
      return n;
   endfunction

   task automatic wait_lasts(input int target, output bit ok);
      int n = 0;
      while (count_lasts() < target && n < 300) begin tick(); n++; end
      ok = (count_lasts() >= target);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'hF; req_args = '1; resp_ready = 1'b1;
      tick(); tick();
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
      checks++; if (gen_start !== 1'b0) begin errors++; $display("FAIL reset_gen_start got %b exp 0", gen_start); end
      checks++; if (gen_ready !== 1'b0) begin errors++; $display("FAIL reset_gen_ready got %b exp 0", gen_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
      checks++; if (resp_last !== 1'b0) begin errors++; $display("FAIL reset_resp_last got %b exp 0", resp_last); end
      checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got %0d exp 0", resp_id); end
      checks++; if (resp_data !== 64'd0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
      checks++; if (gen_args !== '0) begin errors++; $display("FAIL reset_gen_args got %h exp 0", gen_args); end
      req_valid = 4'h0; req_args = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bit ok;
      logic [ARG_W-1:0] exp_args;
      beats.delete(); grants.delete(); grant_cyc.delete(); start_pulses = 0;
      prog_q = '{64'h00000002_00000001, 64'h00000004_00000003};
      prog_delay = 0; prog_early = 0; resp_ready = 1'b1;
      exp_args = {32'd4, 32'd3, 32'd2, 32'd1};
      req_args = '0; req_args[1*ARG_W +: ARG_W] = exp_args; req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_req_ready got %b exp 0010", req_ready); end
      tick();
      req_valid = 4'b0; req_args = '0;
      wait_lasts(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d lasts exp 1", count_lasts()); end
      checks++; if (beats.size() != 3) begin errors++; $display("FAIL single_beat_count got %0d exp 3", beats.size()); end
      if (beats.size() == 3) begin
         checks++; if (beats[0].id !== 2'd1 || beats[0].last !== 1'b0 || beats[0].data !== 64'h00000002_00000001) begin
            errors++; $display("FAIL single_beat0 got id=%0d last=%b data=%h exp id=1 last=0 data=0000000200000001", beats[0].id, beats[0].last, beats[0].data); end
         checks++; if (beats[1].id !== 2'd1 || beats[1].last !== 1'b0 || beats[1].data !== 64'h00000004_00000003) begin
            errors++; $display("FAIL single_beat1 got id=%0d last=%b data=%h exp id=1 last=0 data=0000000400000003", beats[1].id, beats[1].last, beats[1].data); end
         checks++; if (beats[2].id !== 2'd1 || beats[2].last !== 1'b1 || beats[2].data !== 64'd0) begin
            errors++; $display("FAIL single_last got id=%0d last=%b data=%h exp id=1 last=1 data=0", beats[2].id, beats[2].last, beats[2].data); end
         if (grant_cyc.size() > 0) begin
            checks++; if (beats[0].cyc - grant_cyc[0] != 3) begin
               errors++; $display("FAIL single_latency got %0d exp 3", beats[0].cyc - grant_cyc[0]); end
         end
      end
      checks++; if (start_pulses != 1) begin errors++; $display("FAIL single_start_pulses got %0d exp 1", start_pulses); end
      checks++; if (gen_args !== exp_args) begin errors++; $display("FAIL single_gen_args got %h exp %h", gen_args, exp_args); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int n = 0;
      int exp_g[5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      beats.delete(); grants.delete(); grant_cyc.delete();
      prog_q = '{64'h00000000_000000AA};
      for (int r = 0; r < NUM_REQ; r++) req_args[r*ARG_W +: ARG_W] = ARG_W'(r + 16);
      req_valid = 4'hF;
      while (grants.size() < 5 && n < 200) begin tick(); n++; end
      req_valid = 4'h0;
      wait_lasts(5, ok);
      checks++; if (!ok || grants.size() != 5) begin errors++; $display("FAIL rr_grant_count got %0d exp 5", grants.size()); end
      if (grants.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (grants[i] != exp_g[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, grants[i], exp_g[i]); end
         end
      end
      checks++; if (beats.size() != 10) begin errors++; $display("FAIL rr_beat_count got %0d exp 10", beats.size()); end
      checks++; if (gen_args !== ARG_W'(16)) begin errors++; $display("FAIL rr_gen_args got %h exp %h", gen_args, ARG_W'(16)); end
   endtask

   task automatic test_backpressure();
      bit ok;
      beats.delete(); grants.delete(); fire_count = 0; resp_ready = 1'b0;
      prog_q.delete();
      for (int k = 0; k < 5; k++) prog_q.push_back({32'(200 + k), 32'(100 + k)});
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0;
      repeat (10) tick();
      checks++; if (grants.size() != 1 || grants[0] != 3) begin errors++; $display("FAIL bp_grant got size=%0d exp grant 3", grants.size()); end
      checks++; if (fire_count != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", fire_count); end
      checks++; if (gen_ready !== 1'b0) begin errors++; $display("FAIL bp_gen_ready got %b exp 0", gen_ready); end
      checks++; if (resp_valid !== 1'b1 || resp_data !== {32'd200, 32'd100}) begin
         errors++; $display("FAIL bp_head got valid=%b data=%h exp valid=1 data=%h", resp_valid, resp_data, {32'd200, 32'd100}); end
      resp_ready = 1'b1;
      wait_lasts(1, ok);
      checks++; if (!ok || beats.size() != 6) begin errors++; $display("FAIL bp_beat_count got %0d exp 6", beats.size()); end
      if (beats.size() == 6) begin
         for (int k = 0; k < 5; k++) begin
            checks++; if (beats[k].data !== {32'(200 + k), 32'(100 + k)} || beats[k].last !== 1'b0 || beats[k].id !== 2'd3) begin
               errors++; $display("FAIL bp_beat[%0d] got id=%0d last=%b data=%h exp id=3 last=0 data=%h", k, beats[k].id, beats[k].last, beats[k].data, {32'(200 + k), 32'(100 + k)}); end
         end
         checks++; if (beats[5].last !== 1'b1 || beats[5].id !== 2'd3) begin errors++; $display("FAIL bp_last got last=%b id=%0d exp last=1 id=3", beats[5].last, beats[5].id); end
      end
   endtask

   task automatic test_done_with_last();
      bit ok;
      beats.delete(); coincide_seen = 0; resp_ready = 1'b1; prog_early = 1;
      prog_q = '{64'h11, 64'h22, 64'h33};
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0;
      wait_lasts(1, ok);
      prog_early = 0;
      checks++; if (!coincide_seen) begin errors++; $display("FAIL dwl_coincide got 0 exp 1"); end
      checks++; if (!ok || beats.size() != 4) begin errors++; $display("FAIL dwl_beat_count got %0d exp 4", beats.size()); end
      if (beats.size() == 4) begin
         checks++; if (beats[2].data !== 64'h33 || beats[2].last !== 1'b0) begin
            errors++; $display("FAIL dwl_final_yield got data=%h last=%b exp data=33 last=0", beats[2].data, beats[2].last); end
         checks++; if (beats[3].last !== 1'b1 || beats[3].id !== 2'd0) begin
            errors++; $display("FAIL dwl_last got last=%b id=%0d exp last=1 id=0", beats[3].last, beats[3].id); end
      end
   endtask

   task automatic test_stale_done();
      bit ok;
      beats.delete(); stale_seen = 0; prog_q.delete(); prog_delay = 3; resp_ready = 1'b1;
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0;
      wait_lasts(1, ok);
      prog_delay = 0;
      checks++; if (!stale_seen) begin errors++; $display("FAIL stale_seen got 0 exp 1"); end
      checks++; if (!ok || beats.size() != 1) begin errors++; $display("FAIL stale_beat_count got %0d exp 1", beats.size()); end
      if (beats.size() == 1) begin
         checks++; if (beats[0].last !== 1'b1 || beats[0].data !== 64'd0 || beats[0].id !== 2'd1) begin
            errors++; $display("FAIL stale_last got last=%b data=%h id=%0d exp last=1 data=0 id=1", beats[0].last, beats[0].data, beats[0].id); end
         checks++; if (beats[0].cyc != done_cyc + 2) begin
            errors++; $display("FAIL stale_timing got cycle %0d exp %0d", beats[0].cyc, done_cyc + 2); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      beats.delete(); grants.delete(); fire_count = 0; resp_ready = 1'b0;
      prog_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0;
      repeat (6) tick();
      checks++; if (resp_valid !== 1'b1 || fire_count != 2) begin
         errors++; $display("FAIL mid_prefill got valid=%b accepted=%0d exp valid=1 accepted=2", resp_valid, fire_count); end
      req_valid = 4'b0100; grants.delete();
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({req_ready, gen_start, gen_ready, resp_valid, resp_last} !== 8'b0 || resp_id !== 2'd0 || resp_data !== 64'd0 || gen_args !== '0) begin
         errors++; $display("FAIL mid_reset_outputs got rr=%b st=%b gr=%b rv=%b rl=%b id=%0d d=%h exp all 0", req_ready, gen_start, gen_ready, resp_valid, resp_last, resp_id, resp_data); end
      tick(); tick();
      prog_q = '{64'hB1, 64'hB2}; resp_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_regrant got %b exp 0100", req_ready); end
      tick();
      req_valid = 4'b0;
      wait_lasts(1, ok);
      checks++; if (grants.size() != 1 || grants[0] != 2) begin errors++; $display("FAIL mid_grants got size=%0d exp one grant of 2", grants.size()); end
      checks++; if (!ok || beats.size() != 3) begin errors++; $display("FAIL mid_beat_count got %0d exp 3", beats.size()); end
      if (beats.size() == 3) begin
         checks++; if (beats[0].data !== 64'hB1 || beats[1].data !== 64'hB2 || beats[2].last !== 1'b1 || beats[2].id !== 2'd2) begin
            errors++; $display("FAIL mid_beats got %h %h last=%b id=%0d exp B1 B2 last=1 id=2", beats[0].data, beats[1].data, beats[2].last, beats[2].id); end
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_args = '0; resp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_done_with_last();
      test_stale_done();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
